// File: rtl/led_panel_pkg.sv
// Shared FSM encoding, panel constants and the PWM compare helper for the
// front-panel LED serializer.
package led_panel_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4
  } state_e;

  localparam int LED_WIDTH_DEF = 21;
  localparam logic [LED_WIDTH_DEF-1:0] LED_RESET_WORD = 21'h10000;
  localparam int PWM_STEPS  = 16;
  localparam int PWM_STEP_W = $clog2(PWM_STEPS);

  // Panel is lit during the first `level` steps of each PWM period.
  function automatic logic pwm_lit(input logic [PWM_STEP_W-1:0] step,
                                   input logic [PWM_STEP_W-1:0] level);
    return (step < level);
  endfunction

endpackage

// File: rtl/led_panel_serializer_if.sv
// Parallel-in / 595-chain-out signal bundle; master is the PIO side, slave the
// serializer.
interface led_panel_serializer_if #(
  parameter int LED_WIDTH = led_panel_pkg::LED_WIDTH_DEF
);
  logic [LED_WIDTH-1:0] led_in;
  logic [3:0]           brightness;
  logic                 sclk;
  logic                 sdata;
  logic                 latch;
  logic                 oe_n;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output led_in, brightness,
    input  sclk, sdata, latch, oe_n, busy, frame_done
  );

  modport slave (
    input  led_in, brightness,
    output sclk, sdata, latch, oe_n, busy, frame_done
  );
endinterface

// File: rtl/led_panel_pwm.sv
// Brightness PWM for the panel output enable: free-running tick/step counters
// and a registered active-low enable that stays off until a frame is shown.
module led_panel_pwm
  import led_panel_pkg::*;
#(
  parameter int PWM_TICK = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PWM_STEP_W-1:0] brightness_i,
  input  logic                  displayed_i,
  output logic                  oe_n_o
);

  localparam int TW = (PWM_TICK > 1) ? $clog2(PWM_TICK) : 1;

  logic [TW-1:0]         tick_q, tick_d;
  logic [PWM_STEP_W-1:0] step_q, step_d;
  logic                  oe_n_d;

  // Next tick/step count and next enable level.
  always_comb begin
    tick_d = tick_q + TW'(1);
    step_d = step_q;
    if (tick_q == TW'(PWM_TICK - 1)) begin
      tick_d = '0;
      step_d = step_q + PWM_STEP_W'(1);
    end else begin
      step_d = step_q;
    end
    if (displayed_i) begin
      oe_n_d = ~pwm_lit(step_q, brightness_i);
    end else begin
      oe_n_d = 1'b1;
    end
  end

  // Counter and output-enable registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      step_q <= '0;
      oe_n_o <= 1'b1;
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
      oe_n_o <= oe_n_d;
    end
  end

endmodule

// File: rtl/led_panel_serializer.sv
// Shifts the parallel LED word MSB-first into a 595-style chain whenever it
// changes or the refresh timer expires; brightness is PWM on oe_n.
module led_panel_serializer
  import led_panel_pkg::*;
#(
  parameter int LED_WIDTH      = LED_WIDTH_DEF,
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CYCLES = 50000,
  parameter int PWM_TICK       = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  led_panel_serializer_if.slave bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [BW-1:0]        bit_m1;
  logic [LED_WIDTH-1:0] shadow_q, shadow_d;
  logic [LED_WIDTH-1:0] last_q, last_d;
  logic [RW-1:0]        ref_q, ref_d;
  logic                 refp_q, refp_d;
  logic                 first_q, first_d;
  logic                 disp_q, disp_d;
  logic                 sdata_q, sdata_d;
  logic                 sclk_q, sclk_d;
  logic                 latch_q, latch_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));
  assign bit_m1  = bit_q - BW'(1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (first_q || refp_q || (bus.led_in != last_q)) state_d = LOAD;
        else                                             state_d = IDLE;
      end
      LOAD:     state_d = SHIFT_LO;
      SHIFT_LO: begin
        if (div_end) state_d = SHIFT_HI;
        else         state_d = SHIFT_LO;
      end
      SHIFT_HI: begin
        if (!div_end)               state_d = SHIFT_HI;
        else if (bit_q == BW'(0))   state_d = LATCH;
        else                        state_d = SHIFT_LO;
      end
      LATCH: begin
        if (div_end) state_d = IDLE;
        else         state_d = LATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pin outputs are registered from state_d.
  always_comb begin
    shadow_d = shadow_q;
    last_d   = last_q;
    bit_d    = bit_q;
    sdata_d  = sdata_q;
    first_d  = first_q;
    refp_d   = refp_q;
    ref_d    = ref_q;
    disp_d   = disp_q;
    if ((state_d != state_q) || (state_q == IDLE)) div_d = '0;
    else                                            div_d = div_q + DW'(1);
    sclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == LATCH) && (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (ref_q == RW'(REFRESH_CYCLES - 1)) refp_d = 1'b1;
        else                                  ref_d  = ref_q + RW'(1);
      end
      LOAD: begin
        shadow_d = bus.led_in;
        last_d   = bus.led_in;
        sdata_d  = bus.led_in[LED_WIDTH-1];
        bit_d    = BW'(LED_WIDTH - 1);
        first_d  = 1'b0;
        refp_d   = 1'b0;
        ref_d    = '0;
      end
      SHIFT_HI: begin
        if (div_end && (bit_q != BW'(0))) begin
          bit_d   = bit_m1;
          sdata_d = shadow_q[bit_m1];
        end else begin
          bit_d   = bit_q;
        end
      end
      LATCH: begin
        if (div_end) begin
          sdata_d = 1'b0;
          disp_d  = 1'b1;
        end else begin
          disp_d  = disp_q;
        end
      end
      default: begin
        bit_d = bit_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      bit_q    <= '0;
      shadow_q <= '0;
      last_q   <= '0;
      ref_q    <= '0;
      refp_q   <= 1'b0;
      first_q  <= 1'b1;
      disp_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      ref_q    <= ref_d;
      refp_q   <= refp_d;
      first_q  <= first_d;
      disp_q   <= disp_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.sdata      = sdata_q;
  assign bus.latch      = latch_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  led_panel_pwm #(
    .PWM_TICK (PWM_TICK)
  ) u_pwm (
    .clk          (clk),
    .reset_n      (reset_n),
    .brightness_i (bus.brightness),
    .displayed_i  (disp_q),
    .oe_n_o       (bus.oe_n)
  );

endmodule

// File: tb/tb_led_panel_serializer.sv
// Self-checking bench: a monitor decodes the serial stream into frames; tasks
// compare frames, timing and PWM duty against values derived from the rules.
module tb_led_panel_serializer;
  import led_panel_pkg::*;

  localparam int LW = 21;
  localparam int CD = 4;
  localparam int RC = 50;
  localparam int PT = 64;
  localparam int FRAME_LEN = 1 + 2 * CD * LW + CD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  led_panel_serializer_if #(.LED_WIDTH(LW)) bus ();

  led_panel_serializer #(
    .LED_WIDTH      (LW),
    .CLK_DIV        (CD),
    .REFRESH_CYCLES (RC),
    .PWM_TICK       (PT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Frame monitor: rebuilds each word from sdata at sclk rising edges.
  int            cyc = 0;
  int            q_start[$];
  int            q_done[$];
  int            q_bits[$];
  int            q_latch[$];
  logic [LW-1:0] q_word[$];
  logic [LW-1:0] q_exp[$];
  bit            in_frame = 1'b0;
  bit            cap_next = 1'b0;
  int            cur_start, cur_bits, cur_latch;
  logic [LW-1:0] cur_word, cur_exp;
  logic          prev_sclk = 1'b0;
  logic          prev_sdata = 1'b0;
  int            glitches = 0;
  int            stray = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset_n) begin
      in_frame  = 1'b0;
      cap_next  = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (cap_next) begin
        cur_exp  = bus.led_in;
        cap_next = 1'b0;
      end
      if (bus.busy && !in_frame) begin
        in_frame  = 1'b1;
        cur_start = cyc;
        cur_bits  = 0;
        cur_word  = '0;
        cur_latch = 0;
        cap_next  = 1'b1;
      end
      if (in_frame && bus.sclk && !prev_sclk) begin
        cur_word = {cur_word[LW-2:0], bus.sdata};
        cur_bits++;
      end
      if (bus.sclk && prev_sclk && (bus.sdata !== prev_sdata)) glitches++;
      if (in_frame && bus.latch) cur_latch++;
      if (bus.frame_done) begin
        if (in_frame) begin
          q_start.push_back(cur_start);
          q_done.push_back(cyc);
          q_bits.push_back(cur_bits);
          q_latch.push_back(cur_latch);
          q_word.push_back(cur_word);
          q_exp.push_back(cur_exp);
        end else begin
          stray++;
        end
        in_frame = 1'b0;
      end
      prev_sclk  = bus.sclk;
      prev_sdata = bus.sdata;
    end
  end

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = (q_done.size() >= n);
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if (q_done.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.led_in = LED_RESET_WORD;
    bus.brightness = 4'd15;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", bus.sclk); end
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata got %b exp 0", bus.sdata); end
    checks++; if (bus.latch !== 1'b0) begin errors++; $display("FAIL rst_latch got %b exp 0", bus.latch); end
    checks++; if (bus.oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n got %b exp 1", bus.oe_n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.frame_done); end
  endtask

  task automatic test_first_frame();
    int rel;
    int lows;
    bit ok;
    @(negedge clk);
    reset_n = 1'b1;
    rel  = cyc;
    lows = 0;
    ok   = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #2;
      if (q_done.size() >= 1) ok = 1'b1;
      else if (bus.oe_n !== 1'b1) lows++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL first_timeout got %0d frames exp 1", q_done.size()); end
    if (ok) begin
      checks++; if (q_start[0] !== rel + 1) begin errors++; $display("FAIL first_start got %0d exp %0d", q_start[0], rel + 1); end
      checks++; if (q_done[0] - q_start[0] !== FRAME_LEN) begin errors++; $display("FAIL first_len got %0d exp %0d", q_done[0] - q_start[0], FRAME_LEN); end
      checks++; if (q_word[0] !== LED_RESET_WORD) begin errors++; $display("FAIL first_word got %h exp %h", q_word[0], LED_RESET_WORD); end
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL first_oe_n got %0d low cycles exp 0", lows); end
  endtask

  task automatic test_refresh();
    bit ok;
    wait_done(2, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL refresh_timeout got %0d frames exp 2", q_done.size()); end
    if (ok) begin
      checks++; if (q_start[1] - q_done[0] !== RC + 1) begin errors++; $display("FAIL refresh_gap got %0d exp %0d", q_start[1] - q_done[0], RC + 1); end
      checks++; if (q_word[1] !== LED_RESET_WORD) begin errors++; $display("FAIL refresh_word got %h exp %h", q_word[1], LED_RESET_WORD); end
    end
  endtask

  task automatic test_midframe_change();
    bit ok;
    int n;
    logic [LW-1:0] newv;
    newv = '1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(posedge clk); #2;
      if (in_frame && cur_bits == 11) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_wait got %0d bits exp 11", cur_bits); end
    n = q_done.size();
    @(negedge clk);
    bus.led_in = newv;
    wait_done(n + 2, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got %0d frames exp %0d", q_done.size(), n + 2); end
    if (ok) begin
      checks++; if (q_word[n] !== LED_RESET_WORD) begin errors++; $display("FAIL mid_old_word got %h exp %h", q_word[n], LED_RESET_WORD); end
      checks++; if (q_start[n+1] !== q_done[n] + 1) begin errors++; $display("FAIL mid_restart got %0d exp %0d", q_start[n+1], q_done[n] + 1); end
      checks++; if (q_word[n+1] !== newv) begin errors++; $display("FAIL mid_new_word got %h exp %h", q_word[n+1], newv); end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] levels [4];
    int lows;
    levels[0] = 4'd0;
    levels[1] = 4'd8;
    levels[2] = 4'd15;
    levels[3] = 4'($urandom_range(1, 14));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.brightness = levels[k];
      repeat (2) @(posedge clk);
      lows = 0;
      for (int c = 0; c < PWM_STEPS * PT; c++) begin
        @(posedge clk); #2;
        if (bus.oe_n === 1'b0) lows++;
      end
      checks++;
      if (lows !== int'(levels[k]) * PT) begin
        errors++;
        $display("FAIL pwm_duty level %0d got %0d low cycles exp %0d", levels[k], lows, int'(levels[k]) * PT);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int rel;
    int n;
    logic [LW-1:0] v;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(posedge clk); #2;
      if (in_frame && bus.sclk === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait got %b exp 1", bus.sclk); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b exp 0", bus.sclk); end
    checks++; if (bus.latch !== 1'b0) begin errors++; $display("FAIL rstmid_latch got %b exp 0", bus.latch); end
    checks++; if (bus.oe_n !== 1'b1) begin errors++; $display("FAIL rstmid_oe_n got %b exp 1", bus.oe_n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("FAIL rstmid_sdata got %b exp 0", bus.sdata); end
    v = LW'($urandom);
    bus.led_in = v;
    repeat (3) @(negedge clk);
    n = q_done.size();
    reset_n = 1'b1;
    rel = cyc;
    wait_done(n + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d frames exp %0d", q_done.size(), n + 1); end
    if (ok) begin
      checks++; if (q_start[n] !== rel + 1) begin errors++; $display("FAIL rstmid_start got %0d exp %0d", q_start[n], rel + 1); end
      checks++; if (q_done[n] - q_start[n] !== FRAME_LEN) begin errors++; $display("FAIL rstmid_len got %0d exp %0d", q_done[n] - q_start[n], FRAME_LEN); end
      checks++; if (q_word[n] !== v) begin errors++; $display("FAIL rstmid_word got %h exp %h", q_word[n], v); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [LW-1:0] v;
    for (int i = 0; i < 400 && bus.busy !== 1'b0; i++) begin
      @(posedge clk); #2;
    end
    n = q_done.size();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_done.size() > n) break;
      bus.led_in = LW'($urandom);
    end
    checks++; if (q_done.size() !== n + 1) begin errors++; $display("FAIL b2b_one_done got %0d frames exp %0d", q_done.size(), n + 1); end
    v = LW'($urandom);
    if (q_done.size() > n && v == q_word[n]) v = ~v;
    bus.led_in = v;
    wait_done(n + 2, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d frames exp %0d", q_done.size(), n + 2); end
    if (ok) begin
      checks++; if (q_word[n] !== q_exp[n]) begin errors++; $display("FAIL b2b_load_word got %h exp %h", q_word[n], q_exp[n]); end
      checks++; if (q_start[n+1] !== q_done[n] + 1) begin errors++; $display("FAIL b2b_restart got %0d exp %0d", q_start[n+1], q_done[n] + 1); end
      checks++; if (q_word[n+1] !== v) begin errors++; $display("FAIL b2b_word got %h exp %h", q_word[n+1], v); end
    end
    repeat (40) @(posedge clk);
    #2;
    checks++; if (q_done.size() !== n + 2 || in_frame) begin errors++; $display("FAIL b2b_extra got %0d frames busy %b exp %0d frames idle", q_done.size(), in_frame, n + 2); end
  endtask

  task automatic test_frame_integrity();
    for (int i = 0; i < q_done.size(); i++) begin
      checks++; if (q_bits[i] !== LW) begin errors++; $display("FAIL frame%0d_bits got %0d exp %0d", i, q_bits[i], LW); end
      checks++; if (q_latch[i] !== CD) begin errors++; $display("FAIL frame%0d_latch got %0d exp %0d", i, q_latch[i], CD); end
      checks++; if (q_word[i] !== q_exp[i]) begin errors++; $display("FAIL frame%0d_word got %h exp %h", i, q_word[i], q_exp[i]); end
    end
    checks++; if (glitches !== 0) begin errors++; $display("FAIL sdata_stable got %0d changes exp 0", glitches); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL stray_done got %0d exp 0", stray); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_refresh();
    test_midframe_change();
    test_pwm();
    test_reset_midframe();
    test_back_to_back();
    test_frame_integrity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
